// File: rtl/serving_rf_ser_pkg.sv
// Shared constants for the serving bit-serial register-file adapter:
// RF window size, read-FSM encoding and the RF byte-address helper.
package serving_rf_ser_pkg;

    localparam int RF_BYTES = 128;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRE1   = 3'd1;
    localparam logic [2:0] ST_PRE2   = 3'd2;
    localparam logic [2:0] ST_RDY    = 3'd3;
    localparam logic [2:0] ST_STREAM = 3'd4;

    // The RF occupies the top RF_BYTES of the RAM; callers truncate to aw bits.
    function automatic logic [31:0] rf_byte_addr(input int depth,
                                                 input logic [4:0] rreg,
                                                 input logic [1:0] rbyte);
        return 32'(depth - RF_BYTES) + {25'd0, rreg, rbyte};
    endfunction

endpackage

// File: rtl/serving_rf_wr_deser.sv
// Write path: assembles the LSB-first rd stream into bytes and issues one
// RAM write the cycle after each byte's bit 7 arrives.
module serving_rf_wr_deser
    import serving_rf_ser_pkg::*;
#(
    parameter int depth = 256,
    parameter int aw    = $clog2(depth)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wen,
    input  logic [4:0]    i_rd,
    input  logic          i_wdata,
    output logic [aw-1:0] o_waddr,
    output logic [7:0]    o_wdata,
    output logic          o_wen
);

    logic [4:0] cnt;
    logic [6:0] sreg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt     <= 5'd0;
            sreg    <= 7'd0;
            o_wen   <= 1'b0;
            o_waddr <= '0;
            o_wdata <= 8'd0;
        end else begin
            o_wen <= 1'b0;
            if (i_wen) begin
                cnt  <= cnt + 5'd1;
                sreg <= {i_wdata, sreg[6:1]};
                if (cnt[2:0] == 3'd7) begin
                    // x0 is hardwired zero, so its writes never reach the RAM
                    o_wen   <= (i_rd != 5'd0);
                    o_wdata <= {i_wdata, sreg};
                    o_waddr <= aw'(rf_byte_addr(depth, i_rd, cnt[4:3]));
                end
            end else begin
                // An aborted stream restarts at byte 0; the partial byte is lost
                cnt <= 5'd0;
            end
        end
    end

endmodule

// File: rtl/serving_rf_ser.sv
// Bit-serial RF adapter: turns byte-wide RAM reads into lock-step rs1/rs2
// bit streams and the rd bit stream into byte writes.
module serving_rf_ser
    import serving_rf_ser_pkg::*;
#(
    parameter int depth = 256,
    parameter int aw    = $clog2(depth)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rreq,
    input  logic [4:0]    i_rs1,
    input  logic [4:0]    i_rs2,
    output logic          o_ready,
    output logic          o_rs1,
    output logic          o_rs2,
    output logic          o_busy,
    input  logic          i_wen,
    input  logic [4:0]    i_rd,
    input  logic          i_wdata,
    output logic [aw-1:0] o_waddr,
    output logic [7:0]    o_wdata,
    output logic          o_wen,
    output logic [aw-1:0] o_raddr,
    input  logic [7:0]    i_rdata
);

    logic [2:0] state;
    logic [4:0] cnt;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [7:0] hold1;
    logic [7:0] shift1;
    logic [7:0] shift2;
    logic [2:0] pos;
    logic [1:0] bsel;
    logic       more;

    assign pos  = cnt[2:0];
    assign bsel = cnt[4:3];
    assign more = (bsel != 2'd3);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            cnt    <= 5'd0;
            rs1    <= 5'd0;
            rs2    <= 5'd0;
            hold1  <= 8'd0;
            shift1 <= 8'd0;
            shift2 <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: if (i_rreq) begin
                    rs1   <= i_rs1;
                    rs2   <= i_rs2;
                    state <= ST_PRE1;
                end
                ST_PRE1: state <= ST_PRE2;
                ST_PRE2: begin
                    hold1 <= i_rdata;
                    state <= ST_RDY;
                end
                ST_RDY: begin
                    shift1 <= hold1;
                    shift2 <= i_rdata;
                    cnt    <= 5'd0;
                    state  <= ST_STREAM;
                end
                ST_STREAM: begin
                    cnt <= cnt + 5'd1;
                    if (pos == 3'd6 && more)
                        hold1 <= i_rdata;
                    if (pos == 3'd7) begin
                        // rs2's next byte is on i_rdata right now, so it loads directly
                        shift1 <= hold1;
                        shift2 <= i_rdata;
                        if (!more)
                            state <= ST_IDLE;
                    end else begin
                        shift1 <= shift1 >> 1;
                        shift2 <= shift2 >> 1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Next byte is fetched at pos5/6, ahead of any aligned write to the current byte
    always_comb begin
        o_raddr = '0;
        case (state)
            ST_PRE1: o_raddr = aw'(rf_byte_addr(depth, rs1, 2'd0));
            ST_PRE2: o_raddr = aw'(rf_byte_addr(depth, rs2, 2'd0));
            ST_STREAM: begin
                if (more && pos == 3'd5)
                    o_raddr = aw'(rf_byte_addr(depth, rs1, bsel + 2'd1));
                else if (more && pos == 3'd6)
                    o_raddr = aw'(rf_byte_addr(depth, rs2, bsel + 2'd1));
            end
            default: ;
        endcase
    end

    assign o_ready = (state == ST_RDY);
    assign o_busy  = (state != ST_IDLE);
    assign o_rs1   = (state == ST_STREAM) && shift1[0] && (rs1 != 5'd0);
    assign o_rs2   = (state == ST_STREAM) && shift2[0] && (rs2 != 5'd0);

    serving_rf_wr_deser #(
        .depth (depth),
        .aw    (aw)
    ) u_wr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wen   (i_wen),
        .i_rd    (i_rd),
        .i_wdata (i_wdata),
        .o_waddr (o_waddr),
        .o_wdata (o_wdata),
        .o_wen   (o_wen)
    );

endmodule

// File: tb/tb_serving_rf_ser.sv
// Bench for serving_rf_ser: byte RAM model, register-level reference model,
// directed vector table plus randomized read/write sequences.
module tb_serving_rf_ser;

    localparam int DEPTH  = 256;
    localparam int AW     = 8;
    localparam int RFBASE = DEPTH - 128;
    localparam int NCYC   = 40;
    localparam int NONE   = 1000;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_rreq = 1'b0;
    logic [4:0]    i_rs1 = 5'd0;
    logic [4:0]    i_rs2 = 5'd0;
    logic          o_ready, o_rs1, o_rs2, o_busy;
    logic          i_wen = 1'b0;
    logic [4:0]    i_rd = 5'd0;
    logic          i_wdata = 1'b0;
    logic [AW-1:0] o_waddr, o_raddr;
    logic [7:0]    o_wdata;
    logic          o_wen;
    logic [7:0]    i_rdata;

    int checks = 0;
    int errors = 0;

    serving_rf_ser #(.depth(DEPTH), .aw(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rreq(i_rreq), .i_rs1(i_rs1), .i_rs2(i_rs2),
        .o_ready(o_ready), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_busy(o_busy),
        .i_wen(i_wen), .i_rd(i_rd), .i_wdata(i_wdata),
        .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
        .o_raddr(o_raddr), .i_rdata(i_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Shared byte RAM: registered read, read-before-write on collisions
    logic [7:0]    mem [DEPTH];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [7:0]    pre_data = 8'd0;

    always @(posedge i_clk) begin
        if (pre_en)     mem[pre_addr] <= pre_data;
        else if (o_wen) mem[o_waddr] <= o_wdata;
        i_rdata <= mem[o_raddr];
    end

    // Reference: architectural register values as held in RAM
    logic [31:0] rf_mem [32];

    typedef struct {
        string      tag;
        bit         rd_en;
        bit [4:0]   rs1, rs2;
        bit         wr_en;
        bit [4:0]   rd;
        bit [31:0]  wval;
        int         wstart;
        int         rst_at;
        int         extra;
        bit [31:0]  exp1, exp2;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input string tag, input bit rd_en, input bit [4:0] rs1,
                                input bit [4:0] rs2, input bit wr_en, input bit [4:0] rd,
                                input bit [31:0] wval, input int wstart, input int rst_at,
                                input int extra, input bit [31:0] exp1, input bit [31:0] exp2);
        vec_t v;
        v.tag = tag; v.rd_en = rd_en; v.rs1 = rs1; v.rs2 = rs2; v.wr_en = wr_en;
        v.rd = rd; v.wval = wval; v.wstart = wstart; v.rst_at = rst_at; v.extra = extra;
        v.exp1 = exp1; v.exp2 = exp2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int r, input logic [31:0] val);
        for (int b = 0; b < 4; b++) begin
            pre_en   = 1'b1;
            pre_addr = AW'(RFBASE + r * 4 + b);
            pre_data = val[8*b +: 8];
            @(posedge i_clk); #1;
        end
        pre_en = 1'b0;
        rf_mem[r] = val;
    endtask

    // Cycle c=0 is the i_rreq cycle C; everything is checked cycle by cycle
    task automatic run_seq(input vec_t v);
        bit live, e_ready, e_busy, e_rs1, e_rs2, e_wen;
        int k, wb;
        for (int c = 0; c < NCYC; c++) begin
            i_rst  = (c == v.rst_at);
            i_rreq = v.rd_en && (c == 0 || c == v.extra);
            i_rs1  = (c == 0) ? v.rs1 : 5'($urandom);
            i_rs2  = (c == 0) ? v.rs2 : 5'($urandom);
            i_wen  = v.wr_en && c >= v.wstart && c < v.wstart + 32 && c < v.rst_at;
            i_rd   = v.rd;
            if (i_wen) i_wdata = v.wval[c - v.wstart];
            else       i_wdata = 1'($urandom);
            @(negedge i_clk);
            live    = (c < v.rst_at);
            k       = c - 4;
            e_ready = v.rd_en && live && c == 3;
            e_busy  = v.rd_en && live && c >= 1 && c <= 35;
            e_rs1   = 1'b0;
            e_rs2   = 1'b0;
            if (v.rd_en && live && k >= 0 && k < 32) begin
                e_rs1 = v.exp1[k];
                e_rs2 = v.exp2[k];
            end
            wb    = c - v.wstart - 8;
            e_wen = v.wr_en && live && v.rd != 5'd0 && wb >= 0 && wb <= 24 && (wb % 8) == 0;
            chk($sformatf("%s c%0d ready", v.tag, c), 32'(o_ready), 32'(e_ready));
            chk($sformatf("%s c%0d busy", v.tag, c), 32'(o_busy), 32'(e_busy));
            chk($sformatf("%s c%0d rs1", v.tag, c), 32'(o_rs1), 32'(e_rs1));
            chk($sformatf("%s c%0d rs2", v.tag, c), 32'(o_rs2), 32'(e_rs2));
            chk($sformatf("%s c%0d wen", v.tag, c), 32'(o_wen), 32'(e_wen));
            if (e_wen) begin
                chk($sformatf("%s c%0d waddr", v.tag, c), 32'(o_waddr),
                    32'(RFBASE + v.rd * 4 + wb / 8));
                chk($sformatf("%s c%0d wdata", v.tag, c), 32'(o_wdata), 32'(v.wval[wb +: 8]));
            end
            if (c == v.rst_at) begin
                chk($sformatf("%s rst raddr", v.tag), 32'(o_raddr), 32'd0);
                chk($sformatf("%s rst waddr", v.tag), 32'(o_waddr), 32'd0);
                chk($sformatf("%s rst wdata", v.tag), 32'(o_wdata), 32'd0);
            end
            @(posedge i_clk); #1;
        end
        i_rst  = 1'b0;
        i_rreq = 1'b0;
        i_wen  = 1'b0;
        if (v.wr_en && v.rd != 5'd0)
            for (int b = 0; b < 4; b++)
                if (v.wstart + 8 * b + 8 < v.rst_at)
                    rf_mem[v.rd][8*b +: 8] = v.wval[8*b +: 8];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        logic [31:0] val;

        #2;
        chk("reset ready", 32'(o_ready), 32'd0);
        chk("reset busy",  32'(o_busy),  32'd0);
        chk("reset rs1",   32'(o_rs1),   32'd0);
        chk("reset rs2",   32'(o_rs2),   32'd0);
        chk("reset wen",   32'(o_wen),   32'd0);
        chk("reset waddr", 32'(o_waddr), 32'd0);
        chk("reset wdata", 32'(o_wdata), 32'd0);
        chk("reset raddr", 32'(o_raddr), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        for (int r = 0; r < 32; r++) begin
            case (r)
                0:       val = 32'hFFFF_FFFF;
                3:       val = 32'h1111_1111;
                5:       val = 32'hDEAD_BEEF;
                7:       val = 32'h1234_5678;
                12:      val = 32'h5555_5555;
                default: val = $urandom;
            endcase
            preload(r, val);
        end

        vecs[0]  = mk("rd5_7",    1, 5, 7, 0, 0, 32'h0,          0, NONE, -1, 32'hDEADBEEF, 32'h12345678);
        vecs[1]  = mk("wr9",      0, 0, 0, 1, 9, 32'hA5C30F81,   1, NONE, -1, 32'h0,        32'h0);
        vecs[2]  = mk("rd9_5",    1, 9, 5, 0, 0, 32'h0,          0, NONE, -1, 32'hA5C30F81, 32'hDEADBEEF);
        vecs[3]  = mk("wr0",      0, 0, 0, 1, 0, 32'hFFFFFFFF,   1, NONE, -1, 32'h0,        32'h0);
        vecs[4]  = mk("rd0_9",    1, 0, 9, 0, 0, 32'h0,          0, NONE, -1, 32'h0,        32'hA5C30F81);
        vecs[5]  = mk("ovl_rs1",  1, 3, 7, 1, 3, 32'h22222222,   4, NONE, -1, 32'h11111111, 32'h12345678);
        vecs[6]  = mk("rd3_3",    1, 3, 3, 0, 0, 32'h0,          0, NONE, -1, 32'h22222222, 32'h22222222);
        vecs[7]  = mk("rreq_ign", 1, 7, 5, 0, 0, 32'h0,          0, NONE, 10, 32'h12345678, 32'hDEADBEEF);
        vecs[8]  = mk("ovl_rs2",  1, 5, 9, 1, 9, 32'h0BADF00D,   4, NONE, -1, 32'hDEADBEEF, 32'hA5C30F81);
        vecs[9]  = mk("rst_mid",  1, 7, 3, 1, 12, 32'hCAFEBABE,  4, 17,   -1, 32'h12345678, 32'h22222222);
        vecs[10] = mk("rd12_9",   1, 12, 9, 0, 0, 32'h0,         0, NONE, -1, 32'h555555BE, 32'h0BADF00D);

        foreach (vecs[i]) run_seq(vecs[i]);

        for (int n = 0; n < 24; n++) begin
            v.tag    = $sformatf("rnd%0d", n);
            v.rd_en  = 1'b1;
            v.rs1    = 5'($urandom);
            v.rs2    = 5'($urandom);
            v.wr_en  = 1'($urandom);
            v.rd     = ($urandom_range(0, 1) == 1) ? v.rs1 : 5'($urandom);
            v.wval   = $urandom;
            v.wstart = $urandom_range(0, 4);
            v.rst_at = NONE;
            v.extra  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 35) : -1;
            v.exp1   = (v.rs1 == 5'd0) ? 32'd0 : rf_mem[v.rs1];
            v.exp2   = (v.rs2 == 5'd0) ? 32'd0 : rf_mem[v.rs2];
            run_seq(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
